// File: rtl/noekeon_key_loader_if.sv
// rtl/noekeon_key_loader_if.sv - host word stream and key-register write bundle for noekeon_key_loader
// Optional inAbort signal present only when NOEKEON_KEYLD_ABORT_EN is defined.
interface noekeon_key_loader_if #(
  parameter int WORD_W = 32,
  parameter int KEY_W  = 128
);
  localparam int NWORDS = KEY_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic              inValid;
  logic [WORD_W-1:0] inData;
  logic              outReady;
  logic              inCoreBusy;
  logic              outKeyWr;
  logic [KEY_W-1:0]  outKeyData;
  logic              outKeyValid;
  logic [CNT_W-1:0]  outWordCnt;
`ifdef NOEKEON_KEYLD_ABORT_EN
  logic              inAbort;
`endif

  modport slave (
`ifdef NOEKEON_KEYLD_ABORT_EN
    input  inAbort,
`endif
    input  inValid, inData, inCoreBusy,
    output outReady, outKeyWr, outKeyData, outKeyValid, outWordCnt
  );

  modport master (
`ifdef NOEKEON_KEYLD_ABORT_EN
    output inAbort,
`endif
    output inValid, inData, inCoreBusy,
    input  outReady, outKeyWr, outKeyData, outKeyValid, outWordCnt
  );
endinterface

// File: rtl/noekeon_key_loader.sv
// rtl/noekeon_key_loader.sv - collects a 128-bit Noekeon key word by word and strobes it into the key register
// Define NOEKEON_KEYLD_ABORT_EN to add the inAbort partial-key discard input.
module noekeon_key_loader #(
  parameter int WORD_W = 32,
  parameter int KEY_W  = 128
) (
  input  logic                 inClk,
  input  logic                 inReset,
  noekeon_key_loader_if.slave  bus
);
  localparam int NWORDS = KEY_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic {COLLECT = 1'b0, COMMIT = 1'b1} state_t;

  state_t            state, nextState;
  logic [CNT_W-1:0]  count;
  logic [KEY_W-1:0]  shadow;
  logic              keyValid;
  logic              ready;
  logic              keyWr;
  logic              xfer;
  logic              lastWord;
  logic              abort;

`ifdef NOEKEON_KEYLD_ABORT_EN
  assign abort = bus.inAbort;
`else
  assign abort = 1'b0;
`endif

  assign xfer     = bus.inValid & ready;
  assign lastWord = (count == CNT_W'(NWORDS - 1));

  always_ff @(posedge inClk) begin
    if (inReset) begin
      state <= COLLECT;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      COLLECT: if (xfer && lastWord) nextState = COMMIT;
      COMMIT:  if (!bus.inCoreBusy) nextState = COLLECT;
      default: nextState = COLLECT;
    endcase
    if (abort) nextState = COLLECT;
  end

  // Abort masks both the handshake and the strobe so a cancelled commit never reaches the key register.
  always_comb begin
    ready = 1'b0;
    keyWr = 1'b0;
    case (state)
      COLLECT: ready = ~abort;
      COMMIT:  keyWr = ~bus.inCoreBusy & ~abort;
      default: begin
        ready = 1'b0;
        keyWr = 1'b0;
      end
    endcase
  end

  // Big-endian placement: word 0 lands in the most significant slice.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      count    <= '0;
      shadow   <= '0;
      keyValid <= 1'b0;
    end else if (abort) begin
      count    <= '0;
      shadow   <= '0;
    end else begin
      if (xfer) begin
        for (int k = 0; k < NWORDS; k++) begin
          if (count == CNT_W'(k)) begin
            shadow[KEY_W-1-k*WORD_W -: WORD_W] <= bus.inData;
          end
        end
        count <= lastWord ? '0 : count + 1'b1;
      end
      if (keyWr) keyValid <= 1'b1;
    end
  end

  assign bus.outReady    = ready;
  assign bus.outKeyWr    = keyWr;
  assign bus.outKeyData  = shadow;
  assign bus.outKeyValid = keyValid;
  assign bus.outWordCnt  = count;
endmodule

// File: tb/tb_noekeon_key_loader.sv
// tb/tb_noekeon_key_loader.sv - self-checking bench for noekeon_key_loader with a word-list key model
// Covers the inAbort scenarios when NOEKEON_KEYLD_ABORT_EN is defined.
module tb_noekeon_key_loader;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int NWORDS = KEY_W / WORD_W;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  noekeon_key_loader_if #(.WORD_W(WORD_W), .KEY_W(KEY_W)) bus ();

  noekeon_key_loader #(.WORD_W(WORD_W), .KEY_W(KEY_W)) dut (
    .inClk   (clk),
    .inReset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [KEY_W-1:0] modelKey(input logic [WORD_W-1:0] w [NWORDS]);
    logic [KEY_W-1:0] key = '0;
    for (int i = 0; i < NWORDS; i++) key = (key << WORD_W) | KEY_W'(w[i]);
    return key;
  endfunction

  // Sends one key with `gap` idle cycles between words and `busy` core-busy cycles before commit.
  task automatic runKey(input logic [WORD_W-1:0] w [NWORDS], input int gap, input int busy,
                        output int pulseCycle);
    logic [KEY_W-1:0] expKey = modelKey(w);
    int expCnt = 0;
    int startCycle = cycle;
    for (int k = 0; k < NWORDS; k++) begin
      bus.inValid = 1'b1;
      bus.inData  = w[k];
      bus.inCoreBusy = (k == NWORDS - 1 && busy > 0);
      #1;
      checks++;
      if (bus.outReady !== 1'b1 || bus.outKeyWr !== 1'b0) begin
        errors++;
        $display("FAIL word_accept: got ready=%b wr=%b expected ready=1 wr=0", bus.outReady, bus.outKeyWr);
      end
      @(negedge clk);
      bus.inValid = 1'b0;
      expCnt = (expCnt + 1) % NWORDS;
      #1;
      checks++;
      if (bus.outWordCnt !== 2'(expCnt)) begin
        errors++;
        $display("FAIL word_count: got %0d expected %0d", bus.outWordCnt, expCnt);
      end
      if (k < NWORDS - 1) begin
        for (int g = 0; g < gap; g++) begin
          checks++;
          if (bus.outKeyWr !== 1'b0 || bus.outWordCnt !== 2'(expCnt)) begin
            errors++;
            $display("FAIL gap_hold: got wr=%b cnt=%0d expected wr=0 cnt=%0d", bus.outKeyWr, bus.outWordCnt, expCnt);
          end
          @(negedge clk);
          #1;
        end
      end
    end
    for (int b = 0; b < busy; b++) begin
      checks++;
      if (bus.outReady !== 1'b0 || bus.outKeyWr !== 1'b0 || bus.outKeyData !== expKey) begin
        errors++;
        $display("FAIL busy_hold: got ready=%b wr=%b data=%h expected ready=0 wr=0 data=%h",
                 bus.outReady, bus.outKeyWr, bus.outKeyData, expKey);
      end
      @(negedge clk);
      #1;
    end
    bus.inCoreBusy = 1'b0;
    #1;
    pulseCycle = cycle;
    checks++;
    if (bus.outKeyWr !== 1'b1 || bus.outReady !== 1'b0 || bus.outKeyData !== expKey) begin
      errors++;
      $display("FAIL commit_pulse: got wr=%b ready=%b data=%h expected wr=1 ready=0 data=%h",
               bus.outKeyWr, bus.outReady, bus.outKeyData, expKey);
    end
    checks++;
    if (pulseCycle - startCycle !== NWORDS + (NWORDS - 1) * gap + busy) begin
      errors++;
      $display("FAIL commit_latency: got %0d expected %0d", pulseCycle - startCycle,
               NWORDS + (NWORDS - 1) * gap + busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.outKeyWr !== 1'b0 || bus.outReady !== 1'b1 || bus.outKeyValid !== 1'b1 || bus.outWordCnt !== 2'd0) begin
      errors++;
      $display("FAIL post_commit: got wr=%b ready=%b valid=%b cnt=%0d expected 0 1 1 0",
               bus.outKeyWr, bus.outReady, bus.outKeyValid, bus.outWordCnt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.inValid = 1'b1;
    bus.inData = $urandom;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.inValid = 1'b0;
    #1;
    checks++;
    if (bus.outReady !== 1'b1 || bus.outKeyWr !== 1'b0 || bus.outKeyValid !== 1'b0 ||
        bus.outWordCnt !== 2'd0 || bus.outKeyData !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b wr=%b valid=%b cnt=%0d data=%h expected 1 0 0 0 0",
               bus.outReady, bus.outKeyWr, bus.outKeyValid, bus.outWordCnt, bus.outKeyData);
    end
  endtask

  task automatic test_basic;
    logic [WORD_W-1:0] w [NWORDS] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    int p;
    runKey(w, 0, 0, p);
    checks++;
    if (bus.outKeyData !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      errors++;
      $display("FAIL basic_key: got %h expected 00112233445566778899aabbccddeeff", bus.outKeyData);
    end
  endtask

  task automatic test_busy;
    logic [WORD_W-1:0] w [NWORDS] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    int p;
    runKey(w, 0, 10, p);
  endtask

  task automatic test_gaps;
    logic [WORD_W-1:0] w [NWORDS] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    int p;
    runKey(w, 3, 0, p);
  endtask

  task automatic test_reset_mid;
    logic [WORD_W-1:0] ones [NWORDS] = '{default: 32'hFFFFFFFF};
    int p;
    for (int k = 0; k < 2; k++) begin
      bus.inValid = 1'b1;
      bus.inData = $urandom;
      @(negedge clk);
    end
    bus.inData = $urandom;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.inValid = 1'b0;
    #1;
    checks++;
    if (bus.outWordCnt !== 2'd0 || bus.outKeyData !== '0 || bus.outKeyValid !== 1'b0 || bus.outReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%0d data=%h valid=%b ready=%b expected 0 0 0 1",
               bus.outWordCnt, bus.outKeyData, bus.outKeyValid, bus.outReady);
    end
    runKey(ones, 0, 0, p);
  endtask

  task automatic test_back_to_back;
    logic [WORD_W-1:0] a [NWORDS];
    logic [WORD_W-1:0] b [NWORDS] = '{default: 32'hDEADBEEF};
    int p1, p2;
    for (int i = 0; i < NWORDS; i++) a[i] = $urandom;
    runKey(a, 0, 0, p1);
    runKey(b, 0, 0, p2);
    checks++;
    if (p2 - p1 !== NWORDS + 1) begin
      errors++;
      $display("FAIL back_to_back_spacing: got %0d expected %0d", p2 - p1, NWORDS + 1);
    end
  endtask

  task automatic test_random;
    logic [WORD_W-1:0] w [NWORDS];
    int p;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NWORDS; i++) w[i] = $urandom;
      runKey(w, $urandom_range(0, 2), $urandom_range(0, 3), p);
    end
  endtask

`ifdef NOEKEON_KEYLD_ABORT_EN
  task automatic test_abort;
    logic [WORD_W-1:0] w [NWORDS] = '{32'h1, 32'h2, 32'h3, 32'h4};
    int p;
    for (int k = 0; k < 2; k++) begin
      bus.inValid = 1'b1;
      bus.inData = $urandom;
      @(negedge clk);
    end
    bus.inAbort = 1'b1;
    #1;
    checks++;
    if (bus.outReady !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got %b expected 0", bus.outReady);
    end
    @(negedge clk);
    bus.inAbort = 1'b0;
    bus.inValid = 1'b0;
    #1;
    checks++;
    if (bus.outWordCnt !== 2'd0 || bus.outKeyData !== '0) begin
      errors++;
      $display("FAIL abort_clear: got cnt=%0d data=%h expected 0 0", bus.outWordCnt, bus.outKeyData);
    end
    runKey(w, 0, 0, p);
    for (int k = 0; k < NWORDS; k++) begin
      bus.inValid = 1'b1;
      bus.inData = $urandom;
      bus.inCoreBusy = 1'b1;
      @(negedge clk);
    end
    bus.inValid = 1'b0;
    bus.inAbort = 1'b1;
    bus.inCoreBusy = 1'b0;
    #1;
    checks++;
    if (bus.outKeyWr !== 1'b0 || bus.outReady !== 1'b0) begin
      errors++;
      $display("FAIL abort_commit: got wr=%b ready=%b expected 0 0", bus.outKeyWr, bus.outReady);
    end
    @(negedge clk);
    bus.inAbort = 1'b0;
    #1;
    checks++;
    if (bus.outKeyWr !== 1'b0 || bus.outReady !== 1'b1 || bus.outWordCnt !== 2'd0 || bus.outKeyValid !== 1'b1) begin
      errors++;
      $display("FAIL abort_after: got wr=%b ready=%b cnt=%0d valid=%b expected 0 1 0 1",
               bus.outKeyWr, bus.outReady, bus.outWordCnt, bus.outKeyValid);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.inValid = 1'b0;
    bus.inData = '0;
    bus.inCoreBusy = 1'b0;
`ifdef NOEKEON_KEYLD_ABORT_EN
    bus.inAbort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_busy();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef NOEKEON_KEYLD_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
